// File: rtl/logic_unit_pkg.sv
// Shared opcode values, controller state encoding and state-selection helpers
// for the logic-unit bus controller.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_NAND  = 3'd1;
    localparam logic [2:0] OP_OR    = 3'd2;
    localparam logic [2:0] OP_NOR   = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_NOT_A = 3'd6;
    localparam logic [2:0] OP_NOT_B = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_A,
        ST_LOAD_B,
        ST_EXEC,
        ST_UNLOAD
    } state_t;

    // NOT_B never looks at A, so operand A is skipped and left at zero.
    function automatic state_t first_load_state(input logic [2:0] op);
        return (op == OP_NOT_B) ? ST_LOAD_B : ST_LOAD_A;
    endfunction

    // NOT_A never looks at B, so operand B is skipped and left at zero.
    function automatic state_t after_load_a_state(input logic [2:0] op);
        return (op == OP_NOT_A) ? ST_EXEC : ST_LOAD_B;
    endfunction

endpackage

// File: rtl/logic_unit_bus_ctrl_word_shift_reg.sv
// Full-width word register that assembles BUS_W beats (LS beat first), can be
// cleared or parallel-loaded, and shifts out toward the LS end with zero fill.
module word_shift_reg #(
    parameter int DATA_W = 64,
    parameter int BUS_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              shift_in_i,
    input  logic [BUS_W-1:0]  beat_i,
    input  logic              shift_out_i,
    output logic [DATA_W-1:0] word_o
);

    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;

    // Priority: clear beats load, load beats either shift.
    always_comb begin
        word_d = word_q;
        if (clear_i) begin
            word_d = '0;
        end else if (load_i) begin
            word_d = load_data_i;
        end else if (shift_in_i) begin
            word_d = {beat_i, word_q[DATA_W-1:BUS_W]};
        end else if (shift_out_i) begin
            word_d = {{BUS_W{1'b0}}, word_q[DATA_W-1:BUS_W]};
        end
    end

    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/logic_unit_bus_ctrl.sv
// Bus-side controller for the 64-bit logic unit: streams in opcode and operands,
// runs the external logic unit for one cycle, then streams the result back out.
module logic_unit_bus_ctrl
    import logic_unit_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int BUS_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BUS_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BUS_W-1:0]  out_data,
    output logic              out_last,
    output logic              flag_zero,
    output logic              flag_ones,
    output logic              busy,
    output logic [DATA_W-1:0] lu_in_0,
    output logic [DATA_W-1:0] lu_in_1,
    output logic [2:0]        lu_sel,
    input  logic [DATA_W-1:0] lu_out
);

    localparam int BEATS = DATA_W / BUS_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_zero_q, flag_zero_d;
    logic             flag_ones_q, flag_ones_d;

    logic              clear_ops;
    logic              shift_a;
    logic              shift_b;
    logic              load_res;
    logic              shift_res;
    logic [DATA_W-1:0] a_word;
    logic [DATA_W-1:0] b_word;
    logic [DATA_W-1:0] res_word;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        flag_zero_d = flag_zero_q;
        flag_ones_d = flag_ones_q;
        cmd_ready   = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        clear_ops   = 1'b0;
        shift_a     = 1'b0;
        shift_b     = 1'b0;
        load_res    = 1'b0;
        shift_res   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d        = cmd_op;
                    clear_ops   = 1'b1;
                    flag_zero_d = 1'b0;
                    flag_ones_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = first_load_state(cmd_op);
                end
            end
            ST_LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_a = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = after_load_a_state(op_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_b = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = ST_EXEC;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_EXEC: begin
                // Flags come straight from lu_out so they are valid the cycle
                // the result register is loaded.
                load_res    = 1'b1;
                flag_zero_d = (lu_out == '0);
                flag_ones_d = (lu_out == '1);
                cnt_d       = '0;
                state_d     = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                out_valid = 1'b1;
                out_last  = (cnt_q == LAST_BEAT);
                if (out_ready) begin
                    shift_res = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            flag_zero_q <= 1'b0;
            flag_ones_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            flag_zero_q <= flag_zero_d;
            flag_ones_q <= flag_ones_d;
        end
    end

    word_shift_reg #(.DATA_W(DATA_W), .BUS_W(BUS_W)) u_a_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear_ops),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_in_i  (shift_a),
        .beat_i      (in_data),
        .shift_out_i (1'b0),
        .word_o      (a_word)
    );

    word_shift_reg #(.DATA_W(DATA_W), .BUS_W(BUS_W)) u_b_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear_ops),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_in_i  (shift_b),
        .beat_i      (in_data),
        .shift_out_i (1'b0),
        .word_o      (b_word)
    );

    // The result is overwritten in EXEC, so it needs no clear on command accept.
    word_shift_reg #(.DATA_W(DATA_W), .BUS_W(BUS_W)) u_res_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (1'b0),
        .load_i      (load_res),
        .load_data_i (lu_out),
        .shift_in_i  (1'b0),
        .beat_i      ('0),
        .shift_out_i (shift_res),
        .word_o      (res_word)
    );

    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_valid ? res_word[BUS_W-1:0] : '0;
    assign flag_zero = flag_zero_q;
    assign flag_ones = flag_ones_q;
    assign lu_in_0   = a_word;
    assign lu_in_1   = b_word;
    assign lu_sel    = op_q;

endmodule

// File: tb/tb_logic_unit_bus_ctrl.sv
// Self-checking bench for logic_unit_bus_ctrl: a transaction-level model predicts
// result beats and flags, and a per-cycle monitor compares the DUT against it.
module tb_logic_unit_bus_ctrl;

    localparam int DATA_W = 64;
    localparam int BUS_W  = 16;
    localparam int BEATS  = DATA_W / BUS_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BUS_W-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [BUS_W-1:0]  out_data;
    logic              out_last;
    logic              flag_zero;
    logic              flag_ones;
    logic              busy;
    logic [DATA_W-1:0] lu_in_0;
    logic [DATA_W-1:0] lu_in_1;
    logic [2:0]        lu_sel;
    logic [DATA_W-1:0] lu_out;

    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;

    // Transaction-level expectation for the command in flight.
    logic [BUS_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] exp_a, exp_b, exp_res;
    logic [2:0]        exp_op;
    logic [BUS_W-1:0]  got_data[$];
    logic              got_last[$];
    bit                seen_valid;
    int                first_valid_cyc;

    function automatic logic [DATA_W-1:0] ref_lu(input logic [2:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return ~b;
        endcase
    endfunction

    assign lu_out = ref_lu(lu_sel, lu_in_0, lu_in_1);

    logic_unit_bus_ctrl #(.DATA_W(DATA_W), .BUS_W(BUS_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .flag_zero (flag_zero),
        .flag_ones (flag_ones),
        .busy      (busy),
        .lu_in_0   (lu_in_0),
        .lu_in_1   (lu_in_1),
        .lu_sel    (lu_sel),
        .lu_out    (lu_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle monitor: every result beat offered must be the head of the
    // expected queue; it is consumed only on a handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            check("cmd_ready_vs_busy", 64'(cmd_ready), 64'(!busy));
            check("in_ready_and_out_valid", 64'(in_ready & out_valid), 64'(0));
            if (out_valid) begin
                if (!seen_valid) begin
                    seen_valid      = 1'b1;
                    first_valid_cyc = cyc;
                end
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_out_beat");
                end else begin
                    check("out_data", 64'(out_data), 64'(exp_q[0]));
                    check("out_last", 64'(out_last), 64'(exp_q.size() == 1));
                    check("flag_zero", 64'(flag_zero), 64'(exp_res == '0));
                    check("flag_ones", 64'(flag_ones), 64'(exp_res == '1));
                    check("lu_in_0", lu_in_0, exp_a);
                    check("lu_in_1", lu_in_1, exp_b);
                    check("lu_sel", 64'(lu_sel), 64'(exp_op));
                    if (out_ready) begin
                        got_data.push_back(out_data);
                        got_last.push_back(out_last);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        check({tag, "_in_ready"},  64'(in_ready),  64'(0));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_out_last"},  64'(out_last),  64'(0));
        check({tag, "_out_data"},  64'(out_data),  64'(0));
        check({tag, "_busy"},      64'(busy),      64'(0));
        check({tag, "_flag_zero"}, 64'(flag_zero), 64'(0));
        check({tag, "_flag_ones"}, 64'(flag_ones), 64'(0));
        check({tag, "_lu_in_0"},   lu_in_0,        64'(0));
        check({tag, "_lu_in_1"},   lu_in_1,        64'(0));
        check({tag, "_lu_sel"},    64'(lu_sel),    64'(0));
    endtask

    task automatic send_cmd(input logic [2:0] op, output int acc_cyc);
        bit done = 1'b0;
        bit hs;
        acc_cyc   = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            hs = cmd_ready;
            if (hs) acc_cyc = cyc;
            tick();
            if (hs) done = 1'b1;
        end
        cmd_valid = 1'b0;
        if (!done) fail_now("cmd_accept");
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input bit gaps, input bit noise);
        int i = 0;
        bit hs;
        for (int t = 0; t < 400 && i < BEATS; t++) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? w[i*BUS_W +: BUS_W] : BUS_W'($urandom);
            if (noise) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 3'($urandom);
            end
            @(negedge clk);
            hs = in_valid && in_ready;
            tick();
            if (hs) i++;
        end
        in_valid  = 1'b0;
        cmd_valid = 1'b0;
        if (i < BEATS) fail_now("operand_beats");
    endtask

    // mode 0: out_ready always high; 1: random; 2: hold low 3 cycles on beat 2.
    task automatic drain(input int mode, input bit noise);
        int stall = 0;
        for (int t = 0; t < 400 && exp_q.size() > 0; t++) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (got_data.size() == 1 && stall < 3) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (noise) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op    = 3'($urandom);
                in_valid  = 1'($urandom_range(0, 1));
                in_data   = BUS_W'($urandom);
            end
            tick();
        end
        out_ready = 1'b0;
        cmd_valid = 1'b0;
        in_valid  = 1'b0;
        if (exp_q.size() != 0) begin
            fail_now("result_drain");
        end else begin
            check("idle_after_unload", 64'(busy), 64'(0));
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [DATA_W-1:0] a,
                          input logic [DATA_W-1:0] b, input bit gaps,
                          input int omode, input bit noise, output int lat);
        int acc;
        exp_op  = op;
        exp_a   = (op == 3'd7) ? '0 : a;
        exp_b   = (op == 3'd6) ? '0 : b;
        exp_res = ref_lu(op, exp_a, exp_b);
        exp_q.delete();
        for (int i = 0; i < BEATS; i++) exp_q.push_back(exp_res[i*BUS_W +: BUS_W]);
        got_data.delete();
        got_last.delete();
        seen_valid = 1'b0;
        send_cmd(op, acc);
        if (op != 3'd7) send_word(a, gaps, noise);
        if (op != 3'd6) send_word(b, gaps, noise);
        @(negedge clk);
        check("in_ready_after_load", 64'(in_ready), 64'(0));
        drain(omode, noise);
        lat = first_valid_cyc - acc;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc;
        logic [BUS_W-1:0] t1_beats [4] = '{16'h0000, 16'h0F0F, 16'h0000, 16'h0F0F};
        logic [DATA_W-1:0] ra, rb;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: AND, full throughput, latency and literal beats.
        run_op(3'd0, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 1'b0, 0, 1'b0, lat);
        check("t1_latency", 64'(lat), 64'(2*BEATS + 2));
        check("t1_beat_count", 64'(got_data.size()), 64'(4));
        if (got_data.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t1_beat", 64'(got_data[i]), 64'(t1_beats[i]));
                check("t1_last", 64'(got_last[i]), 64'(i == 3));
            end
        end
        check("t1_flag_zero", 64'(flag_zero), 64'(0));
        check("t1_flag_ones", 64'(flag_ones), 64'(0));

        // 2: NOT_A with A=0, only 4 operand beats.
        run_op(3'd6, 64'h0, 64'hDEADBEEF_CAFEF00D, 1'b0, 0, 1'b0, lat);
        check("t2_flag_ones", 64'(flag_ones), 64'(1));
        check("t2_lu_in_1", lu_in_1, 64'(0));
        foreach (got_data[i]) check("t2_beat", 64'(got_data[i]), 64'hFFFF);

        // 3: XOR then XNOR of identical operands.
        run_op(3'd4, 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 1'b0, 0, 1'b0, lat);
        check("t3_flag_zero", 64'(flag_zero), 64'(1));
        foreach (got_data[i]) check("t3_beat", 64'(got_data[i]), 64'h0000);
        run_op(3'd5, 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 1'b0, 0, 1'b0, lat);
        check("t3_flag_ones", 64'(flag_ones), 64'(1));

        // 4: OR with back-pressure on beat 2.
        run_op(3'd2, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 2, 1'b0, lat);
        check("t4_beat_count", 64'(got_data.size()), 64'(4));

        // 5: reset during LOAD_B beat 2, then NAND of zeros.
        exp_q.delete();
        send_cmd(3'd0, acc);
        send_word(64'hA5A5A5A5A5A5A5A5, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h1111;
        tick();
        in_data  = 16'h2222;
        #2 rst_n = 1'b0;
        #1 check_reset("t5_midreset");
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        run_op(3'd1, 64'h0, 64'h0, 1'b0, 0, 1'b0, lat);
        foreach (got_data[i]) check("t5_beat", 64'(got_data[i]), 64'hFFFF);
        check("t5_flag_ones", 64'(flag_ones), 64'(1));

        // 6: stray in_valid in IDLE, then cmd/in noise while busy.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = BUS_W'($urandom);
            @(negedge clk);
            check("t6_idle_in_ready", 64'(in_ready), 64'(0));
            check("t6_idle_busy", 64'(busy), 64'(0));
            tick();
        end
        in_valid = 1'b0;
        run_op(3'd3, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1, 1'b1, lat);
        run_op(3'd7, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 0, 1'b1, lat);

        // Random mix.
        for (int n = 0; n < 20; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (n % 5 == 0) rb = ra;
            run_op(3'($urandom), ra, rb, 1'b1, 1, 1'($urandom_range(0, 1)), lat);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
